xor6_eval_arb: RTL and testbench
================================

XOR6_EVAL_ARB -- requirements
Module: xor6_eval_arb

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port req, input, 4 bits: per-requester evaluation request; req[k] is held high until ack[k].
REQ-004 The block SHALL have the port din, input, 24 bits: requester k operand on din[6k+5:6k]; stable while req[k] is high.
REQ-005 The block SHALL have the port ack, output, 4 bits: one-cycle, one-hot completion pulse.
REQ-006 The block SHALL have the port rsp, output, 1 bit: evaluator result for the acked requester; holds until the next ack.
REQ-007 The block SHALL have the port rsp_id, output, 2 bits: index of the last acked requester.
REQ-008 The block SHALL have the port ev_in, output, 6 bits, registered: operand driven to the shared 6-input evaluator (i0..i5 = ev_in[0..5]).
REQ-009 The block SHALL have the port ev_out, input, 1 bit: evaluator output (i6), combinational from ev_in.
REQ-010 The block SHALL have the port st_start, input, 1 bit: single-cycle self-test sweep request.
REQ-011 The block SHALL have the port st_busy, output, 1 bit: high while a sweep runs.
REQ-012 The block SHALL have the port st_done, output, 1 bit: one-cycle pulse at sweep end.
REQ-013 The block SHALL have the port st_err_cnt, output, 7 bits: mismatch count of the last sweep (0..64).
REQ-014 The block SHALL have the port st_fail, output, 1 bit: high when st_err_cnt != 0; valid from st_done, held until the next sweep starts.

Function
REQ-015 The FSM SHALL have states IDLE, EVAL, RESP and SWEEP.
REQ-016 In IDLE, when st_start is high, the block SHALL enter SWEEP; st_start SHALL have priority over req in the same cycle.
REQ-017 In IDLE, when st_start is low and req != 0, the block SHALL grant round-robin: search ptr, ptr+1, ... (mod 4); latch the winner index; load ev_in with the winner's din slice; enter EVAL.
REQ-018 In EVAL (one cycle), the block SHALL register ev_out into rsp and the winner index into rsp_id, then enter RESP.
REQ-019 In RESP (one cycle), the block SHALL drive ack[winner]=1, set ptr = winner+1 mod 4, and return to IDLE.
REQ-020 Latency: req sampled in IDLE at cycle t SHALL produce ack at cycle t+2; at most one grant SHALL be made per 3 cycles.
REQ-021 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-022 In IDLE with no grant, ev_in SHALL hold its last value.
REQ-023 On entry to SWEEP, the block SHALL clear st_err_cnt, set vector counter v=0, and drive ev_in=v.
REQ-024 In each SWEEP cycle, the block SHALL compare ev_out with the XOR of all six bits of v; on mismatch it SHALL increment st_err_cnt; then v increments.
REQ-025 After v=63 is compared (64 SWEEP cycles), the block SHALL pulse st_done, update st_fail, drop st_busy, and return to IDLE; ev_in SHALL hold 63.
REQ-026 st_start SHALL be ignored outside IDLE; req SHALL be held pending (no ack) during SWEEP and served afterwards.
REQ-027 st_err_cnt SHALL not wrap: its maximum reachable value is 64.
REQ-028 ack SHALL never have more than one bit set.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously force state=IDLE, ptr=0, ev_in=0, ack=0, rsp=0, rsp_id=0, st_busy=0, st_done=0, st_err_cnt=0, st_fail=0, and v=0.
REQ-030 On reset mid-transaction or mid-sweep, the block SHALL abort with no ack and no st_done; operation SHALL restart cleanly on the first edge after rst_n rises.

Verification
REQ-031 With ev_out = XOR of ev_in, req=0001 and din[5:0]=6'b101101: the bench SHALL check ack=0001 two cycles later with rsp=0 and rsp_id=0.
REQ-032 With req=1111 held continuously: the bench SHALL check the ack order 0001,0010,0100,1000,0001, one ack every 3 cycles.
REQ-033 With a correct evaluator and st_start pulsed: the bench SHALL check st_busy for 64 cycles, then st_done with st_err_cnt=0 and st_fail=0.
REQ-034 With an evaluator stuck at 0 and a sweep run: the bench SHALL check st_err_cnt=32 and st_fail=1; with an inverted evaluator it SHALL check st_err_cnt=64.
REQ-035 With st_start and req=0100 in the same IDLE cycle: the bench SHALL check that the sweep runs first and ack=0100 arrives after st_done.
REQ-036 With rst_n asserted during EVAL and again at sweep cycle 30: the bench SHALL check no ack, no st_done, all outputs at reset values, and correct subsequent operation.

Source files
------------

// File: rtl/xor6_eval_arb.sv
// Round-robin arbiter that shares one 6-input evaluator between four requesters,
// plus a self-test sweep that checks the evaluator against 6-input XOR parity.
module xor6_eval_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [23:0] din,
  output logic [3:0]  ack,
  output logic        rsp,
  output logic [1:0]  rsp_id,
  output logic [5:0]  ev_in,
  input  logic        ev_out,
  input  logic        st_start,
  output logic        st_busy,
  output logic        st_done,
  output logic [6:0]  st_err_cnt,
  output logic        st_fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    RESP  = 2'd2,
    SWEEP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_win;
  logic [5:0]  r_ev;
  logic [5:0]  r_v;
  logic [3:0]  r_ack;
  logic        r_rsp;
  logic [1:0]  r_rsp_id;
  logic        r_busy;
  logic        r_done;
  logic [6:0]  r_err;
  logic        r_fail;

  logic        w_any;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic [5:0]  w_slice;
  logic        w_mis;
  logic [6:0]  w_err_nxt;

  // First requester found scanning upward from r_ptr, wrapping mod 4.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_slice = '0;
    case (w_win)
      2'd0: w_slice = din[5:0];
      2'd1: w_slice = din[11:6];
      2'd2: w_slice = din[17:12];
      2'd3: w_slice = din[23:18];
      default: w_slice = '0;
    endcase
  end

  assign w_mis     = ev_out ^ (^r_v);
  assign w_err_nxt = r_err + 7'(w_mis);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (st_start)   w_next = SWEEP;
        else if (w_any) w_next = EVAL;
      end
      EVAL:  w_next = RESP;
      RESP:  w_next = IDLE;
      SWEEP: if (r_v == 6'd63) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_ev     <= '0;
      r_v      <= '0;
      r_ack    <= '0;
      r_rsp    <= 1'b0;
      r_rsp_id <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
      r_fail   <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (st_start) begin
            r_err  <= '0;
            r_fail <= 1'b0;
            r_v    <= '0;
            r_ev   <= '0;
            r_busy <= 1'b1;
          end else if (w_any) begin
            r_win <= w_win;
            r_ev  <= w_slice;
          end
        end
        // ack is registered here so it appears in the RESP cycle alongside rsp.
        EVAL: begin
          r_rsp    <= ev_out;
          r_rsp_id <= r_win;
          r_ack    <= 4'b0001 << r_win;
        end
        RESP: r_ptr <= r_win + 2'd1;
        SWEEP: begin
          r_err <= w_err_nxt;
          r_v   <= r_v + 6'd1;
          if (r_v == 6'd63) begin
            r_done <= 1'b1;
            r_fail <= (w_err_nxt != '0);
            r_busy <= 1'b0;
          end else begin
            r_ev <= r_v + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack        = r_ack;
  assign rsp        = r_rsp;
  assign rsp_id     = r_rsp_id;
  assign ev_in      = r_ev;
  assign st_busy    = r_busy;
  assign st_done    = r_done;
  assign st_err_cnt = r_err;
  assign st_fail    = r_fail;

endmodule

// File: tb/tb_xor6_eval_arb.sv
// Bench for xor6_eval_arb: a timestamped transaction model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_xor6_eval_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [23:0] din = '0;
  logic        st_start = 1'b0;
  logic [3:0]  ack;
  logic        rsp;
  logic [1:0]  rsp_id;
  logic [5:0]  ev_in;
  logic        ev_out;
  logic        st_busy;
  logic        st_done;
  logic [6:0]  st_err_cnt;
  logic        st_fail;

  int unsigned mode = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator: 0 = correct parity, 1 = stuck at 0, 2 = inverted parity.
  function automatic logic evalfn(input int unsigned md, input logic [5:0] v);
    case (md)
      0:       return ^v;
      1:       return 1'b0;
      default: return ~(^v);
    endcase
  endfunction

  assign ev_out = evalfn(mode, ev_in);

  xor6_eval_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack), .rsp(rsp),
    .rsp_id(rsp_id), .ev_in(ev_in), .ev_out(ev_out), .st_start(st_start),
    .st_busy(st_busy), .st_done(st_done), .st_err_cnt(st_err_cnt), .st_fail(st_fail)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic int err_upto(input int unsigned md, input int n);
    int e;
    logic [5:0] vv;
    e = 0;
    for (int v = 0; v < n; v++) begin
      vv = 6'(v);
      if (evalfn(md, vv) != ^vv) e++;
    end
    return e;
  endfunction

  // Transaction model: each grant/sweep is scheduled with absolute cycle stamps.
  int          mc = 0;
  int          m_free = 0;
  int          m_ack_cyc = -1;
  int          m_sw = -1000;
  int          m_ptr = 0;
  int          m_pid = 0;
  int          m_id = 0;
  logic        m_prsp = 1'b0;
  logic        m_rsp = 1'b0;
  logic [3:0]  m_pack = '0;
  logic [5:0]  m_ev = '0;
  bit          m_swept = 1'b0;
  int unsigned m_swmode = 0;

  always @(negedge clk) begin
    logic [3:0] e_ack;
    logic [5:0] e_ev;
    bit in_sw, found;
    int e_cnt, w, k;
    logic e_fail;
    mc++;
    if (!rst_n) begin
      m_free = 0; m_ack_cyc = -1; m_sw = -1000; m_ptr = 0; m_pid = 0; m_id = 0;
      m_prsp = 1'b0; m_rsp = 1'b0; m_pack = '0; m_ev = '0; m_swept = 1'b0;
    end
    e_ack = '0;
    if (mc == m_ack_cyc) begin
      e_ack = m_pack;
      m_rsp = m_prsp;
      m_id  = m_pid;
    end
    in_sw = m_swept && (mc >= m_sw) && (mc < m_sw + 64);
    e_ev  = in_sw ? 6'(mc - m_sw) : m_ev;
    if (!m_swept) begin
      e_cnt = 0; e_fail = 1'b0;
    end else if (in_sw) begin
      e_cnt = err_upto(m_swmode, mc - m_sw); e_fail = 1'b0;
    end else begin
      e_cnt = err_upto(m_swmode, 64); e_fail = (e_cnt != 0);
    end
    check("m_ack", 32'(ack), 32'(e_ack));
    check("m_rsp", 32'(rsp), 32'(m_rsp));
    check("m_rsp_id", 32'(rsp_id), 32'(m_id));
    check("m_ev_in", 32'(ev_in), 32'(e_ev));
    check("m_st_busy", 32'(st_busy), 32'(in_sw));
    check("m_st_done", 32'(st_done), 32'(m_swept && (mc == m_sw + 64)));
    check("m_st_err_cnt", 32'(st_err_cnt), 32'(e_cnt));
    check("m_st_fail", 32'(st_fail), 32'(e_fail));
    if (rst_n && mc >= m_free) begin
      if (st_start) begin
        m_sw = mc + 1; m_free = mc + 65; m_swept = 1'b1; m_swmode = mode; m_ev = 6'd63;
      end else if (req != '0) begin
        found = 1'b0; w = 0;
        for (int i = 0; i < 4; i++) begin
          k = (m_ptr + i) % 4;
          if (!found && req[k]) begin found = 1'b1; w = k; end
        end
        m_ev      = din[6*w +: 6];
        m_prsp    = evalfn(mode, m_ev);
        m_pid     = w;
        m_pack    = 4'(1 << w);
        m_ack_cyc = mc + 2;
        m_free    = mc + 3;
        m_ptr     = (w + 1) % 4;
      end
    end
  end

  task automatic wait_ack(input string nm, output logic [3:0] a, output int at);
    bit got;
    got = 1'b0; a = '0; at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != '0) begin a = ack; at = cyc; got = 1'b1; break; end
    end
    if (!got) timeout(nm);
  endtask

  task automatic run_sweep(input string nm, output int nb, output logic [6:0] err,
                           output logic fail, output logic bz);
    bit got;
    got = 1'b0; nb = 0; err = '0; fail = 1'b0; bz = 1'b1;
    @(posedge clk); #1 st_start = 1'b1;
    @(posedge clk); #1 st_start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (st_busy) nb++;
      if (st_done) begin
        err = st_err_cnt; fail = st_fail; bz = st_busy; got = 1'b1; break;
      end
    end
    if (!got) timeout(nm);
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] err;
    logic       fail, bz;
    int         at, nb, tprev, done_at, nd;
    logic [3:0] exp_order [5];
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_ev_in", 32'(ev_in), 0);
    check("rst_st_err_cnt", 32'(st_err_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // All four held: strict rotation, one ack per 3 cycles.
    din = 24'b101010_110011_000111_101101;
    req = 4'b1111;
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack("rr_ack_wait", a, at);
      check("rr_order", 32'(a), 32'(exp_order[i]));
      if (i > 0) check("rr_spacing", 32'(at - tprev), 3);
      tprev = at;
    end
    @(posedge clk); #1 req = '0;

    // Single requester 0, parity of 101101 is 0, ack two cycles after sampling.
    repeat (2) @(posedge clk);
    #1 din = '0; din[5:0] = 6'b101101; req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    check("lat_no_ack_eval", 32'(ack), 0);
    @(negedge clk);
    check("lat_ack", 32'(ack), 32'(4'b0001));
    check("lat_rsp", 32'(rsp), 0);
    check("lat_rsp_id", 32'(rsp_id), 0);
    @(posedge clk); #1 req = '0;

    // Requester 1, parity of 000111 is 1.
    repeat (2) @(posedge clk);
    #1 din[11:6] = 6'b000111; req = 4'b0010;
    wait_ack("r1_wait", a, at);
    check("r1_ack", 32'(a), 32'(4'b0010));
    check("r1_rsp", 32'(rsp), 1);
    check("r1_rsp_id", 32'(rsp_id), 1);
    @(posedge clk); #1 req = '0;

    // ptr now 2: requesters 1 and 3 pending, 3 wins first.
    repeat (2) @(posedge clk);
    #1 din[23:18] = 6'b111111; req = 4'b1010;
    wait_ack("rr2_wait", a, at);
    check("rr2_first", 32'(a), 32'(4'b1000));
    check("rr2_rsp", 32'(rsp), 0);
    @(posedge clk); #1 req = 4'b0010;
    wait_ack("rr2b_wait", a, at);
    check("rr2_second", 32'(a), 32'(4'b0010));
    check("rr2_rsp_id", 32'(rsp_id), 1);
    @(posedge clk); #1 req = '0;

    // Sweeps: correct, stuck-at-0, inverted evaluator.
    repeat (2) @(posedge clk);
    run_sweep("sw_ok", nb, err, fail, bz);
    check("sw_ok_busy_cycles", 32'(nb), 64);
    check("sw_ok_err", 32'(err), 0);
    check("sw_ok_fail", 32'(fail), 0);
    check("sw_ok_busy_at_done", 32'(bz), 0);
    mode = 1;
    run_sweep("sw_stuck0", nb, err, fail, bz);
    check("sw_stuck0_err", 32'(err), 32);
    check("sw_stuck0_fail", 32'(fail), 1);
    mode = 2;
    run_sweep("sw_inv", nb, err, fail, bz);
    check("sw_inv_err", 32'(err), 64);
    check("sw_inv_fail", 32'(fail), 1);
    mode = 0;

    // st_start and req in the same IDLE cycle: sweep first, then ack.
    repeat (2) @(posedge clk);
    #1 st_start = 1'b1; din[17:12] = 6'b110000; req = 4'b0100;
    @(posedge clk); #1 st_start = 1'b0;
    done_at = -1; at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (st_done) done_at = cyc;
      if (ack != '0) begin a = ack; at = cyc; break; end
    end
    if (at < 0) timeout("prio_ack_wait");
    else begin
      check("prio_ack", 32'(a), 32'(4'b0100));
      check("prio_done_first", 32'(done_at >= 0 && at > done_at), 1);
    end
    @(posedge clk); #1 req = '0;

    // Reset during EVAL: no ack, outputs cleared, request served after release.
    repeat (2) @(posedge clk);
    #1 din[5:0] = 6'b000001; req = 4'b0001;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_eval_ack", 32'(ack), 0);
    check("rst_eval_rsp", 32'(rsp), 0);
    check("rst_eval_ev_in", 32'(ev_in), 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ack("rst_eval_after", a, at);
    check("rst_eval_after_ack", 32'(a), 32'(4'b0001));
    check("rst_eval_after_rsp", 32'(rsp), 1);
    @(posedge clk); #1 req = '0;

    // Reset at sweep cycle 30: no st_done afterwards, then a clean sweep.
    repeat (2) @(posedge clk);
    #1 st_start = 1'b1;
    @(posedge clk); #1 st_start = 1'b0;
    nb = 0;
    for (int i = 0; i < 100 && nb < 31; i++) begin
      @(negedge clk);
      if (st_busy) nb++;
    end
    if (nb < 31) timeout("rst_sw_reach30");
    #2 rst_n = 1'b0;
    #1;
    check("rst_sw_busy", 32'(st_busy), 0);
    check("rst_sw_err", 32'(st_err_cnt), 0);
    check("rst_sw_ev_in", 32'(ev_in), 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (st_done) nd++;
    end
    check("rst_sw_no_done", 32'(nd), 0);
    run_sweep("sw_after_rst", nb, err, fail, bz);
    check("sw_after_rst_busy", 32'(nb), 64);
    check("sw_after_rst_err", 32'(err), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
